// File: rtl/irq_ctrl_pkg.sv
// Shared encodings for the interrupt request controller.
package irq_ctrl_pkg;

  localparam int IRQ_ID_W = 5;

  typedef enum logic [1:0] {
    IRQ_ST_IDLE = 2'd0,
    IRQ_ST_REQ  = 2'd1,
    IRQ_ST_SERV = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// One-bit synchroniser followed by a rising-edge detector; the edge pulse is valid
// SYNC_STAGES cycles after the source is first sampled, and the pulse lasts one cycle.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_src,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_src};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt request controller feeding cp0: sticky pending bits, mask, fixed priority
// (index 0 highest); one request held until ack, then blocked until eret.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_IRQ-1:0]  i_irq_src,
  input  logic                i_mask_we,
  input  logic [NUM_IRQ-1:0]  i_mask_wdata,
  input  logic                i_ir_ack,
  input  logic                i_eret,
  output logic                o_ir_out,
  output logic [IRQ_ID_W-1:0] o_irq_id,
  output logic [NUM_IRQ-1:0]  o_pending,
  output logic [NUM_IRQ-1:0]  o_mask
);

  function automatic logic [IRQ_ID_W-1:0] f_prio(input logic [NUM_IRQ-1:0] v);
    f_prio = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) f_prio = i[IRQ_ID_W-1:0];
    end
  endfunction

  irq_state_e          r_state, w_state_nxt;
  logic                r_ir_out;
  logic [IRQ_ID_W-1:0] r_irq_id, w_irq_id_nxt, w_grant;
  logic [NUM_IRQ-1:0]  r_pending, r_mask;
  logic [NUM_IRQ-1:0]  w_edge, w_eligible, w_id_onehot, w_clr;
  logic                w_id_enabled;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_src  (i_irq_src[g]),
      .o_edge (w_edge[g])
    );
  end

  always_comb begin
    w_eligible = r_pending & r_mask;
    w_grant    = f_prio(w_eligible);
    // Decoded form of the held id; avoids indexing a narrow vector with a 5-bit id.
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_id_onehot[i] = (r_irq_id == IRQ_ID_W'(i));
    end
    w_id_enabled = |(r_mask & w_id_onehot);
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_irq_id_nxt = r_irq_id;
    w_clr        = '0;
    case (r_state)
      IRQ_ST_IDLE: begin
        if (|w_eligible) begin
          w_state_nxt  = IRQ_ST_REQ;
          w_irq_id_nxt = w_grant;
        end
      end
      IRQ_ST_REQ: begin
        // Ack wins over a same-cycle mask drop: cp0 has already taken the interrupt.
        if (i_ir_ack) begin
          w_state_nxt = IRQ_ST_SERV;
          w_clr       = w_id_onehot;
        end else if (!w_id_enabled) begin
          w_state_nxt = IRQ_ST_IDLE;
        end
      end
      IRQ_ST_SERV: begin
        if (i_eret) w_state_nxt = IRQ_ST_IDLE;
      end
      default: w_state_nxt = IRQ_ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IRQ_ST_IDLE;
      r_ir_out  <= 1'b0;
      r_irq_id  <= '0;
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ir_out  <= (w_state_nxt == IRQ_ST_REQ);
      r_irq_id  <= w_irq_id_nxt;
      // A new edge on the bit being cleared keeps it pending.
      r_pending <= (r_pending & ~w_clr) | w_edge;
      if (i_mask_we) r_mask <= i_mask_wdata;
    end
  end

  assign o_ir_out  = r_ir_out;
  assign o_irq_id  = r_irq_id;
  assign o_pending = r_pending;
  assign o_mask    = r_mask;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: cycle vector table, directed corner sequences, then random
// traffic checked against a behavioural model of the controller.
module tb_irq_ctrl;

  localparam int N = 8;
  localparam int S = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] irq_src;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic         ir_ack;
  logic         eret;
  logic         ir_out;
  logic [4:0]   irq_id;
  logic [N-1:0] pending;
  logic [N-1:0] mask;

  int n_checks = 0;
  int n_errors = 0;

  irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(S)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_irq_src   (irq_src),
    .i_mask_we   (mask_we),
    .i_mask_wdata(mask_wdata),
    .i_ir_ack    (ir_ack),
    .i_eret      (eret),
    .o_ir_out    (ir_out),
    .o_irq_id    (irq_id),
    .o_pending   (pending),
    .o_mask      (mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: source history as a delay line, controller as three modes.
  // Mode 0 = waiting, 1 = requesting, 2 = in service.
  logic [N-1:0] m_hist [0:S];
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_mask = '0;
  int           m_mode = 0;
  int           m_id   = 0;

  function automatic int lowest_set(input logic [N-1:0] v);
    int x;
    x = int'(v);
    return $clog2(x & -x);
  endfunction

  task automatic model_step();
    logic [N-1:0] rise;
    logic [N-1:0] clr;
    if (!rst_n) begin
      for (int k = 0; k <= S; k++) m_hist[k] = '0;
      m_pend = '0;
      m_mask = '0;
      m_mode = 0;
      m_id   = 0;
    end else begin
      rise = m_hist[S-1] & ~m_hist[S];
      clr  = '0;
      if (m_mode == 0) begin
        if ((m_pend & m_mask) != 0) begin
          m_id   = lowest_set(m_pend & m_mask);
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (ir_ack) begin
          clr    = N'(1) << m_id;
          m_mode = 2;
        end else if (!m_mask[m_id]) begin
          m_mode = 0;
        end
      end else if (eret) begin
        m_mode = 0;
      end
      m_pend = (m_pend & ~clr) | rise;
      if (mask_we) m_mask = mask_wdata;
      for (int k = S; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = irq_src;
    end
  endtask

  // Inputs are set just after a negedge; outputs are sampled at the following negedge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         rst_n;
    logic [N-1:0] src;
    logic         mwe;
    logic [N-1:0] mdat;
    logic         ack;
    logic         eret;
    logic         exp_ir;
    logic [4:0]   exp_id;
    logic [N-1:0] exp_pend;
    logic [N-1:0] exp_mask;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [N-1:0] s, input logic we,
                              input logic [N-1:0] md, input logic a, input logic e,
                              input logic ir, input logic [4:0] id,
                              input logic [N-1:0] p, input logic [N-1:0] m);
    vec_t v;
    v.rst_n = r; v.src = s; v.mwe = we; v.mdat = md; v.ack = a; v.eret = e;
    v.exp_ir = ir; v.exp_id = id; v.exp_pend = p; v.exp_mask = m;
    return v;
  endfunction

  vec_t vecs [0:16];

  initial begin
    for (int k = 0; k <= S; k++) m_hist[k] = '0;
    //              rst src    we mdat   ack eret  ir id    pend   mask
    vecs[0]  = mk(0, 8'hFF, 0, 8'h00, 0, 0,   0, 5'd0, 8'h00, 8'h00);
    vecs[1]  = mk(0, 8'hFF, 0, 8'h00, 0, 0,   0, 5'd0, 8'h00, 8'h00);
    vecs[2]  = mk(0, 8'hFF, 0, 8'h00, 0, 0,   0, 5'd0, 8'h00, 8'h00);
    vecs[3]  = mk(1, 8'hFF, 0, 8'h00, 0, 0,   0, 5'd0, 8'h00, 8'h00);
    vecs[4]  = mk(1, 8'hFF, 0, 8'h00, 0, 0,   0, 5'd0, 8'h00, 8'h00);
    vecs[5]  = mk(1, 8'hFF, 0, 8'h00, 0, 0,   0, 5'd0, 8'hFF, 8'h00);
    vecs[6]  = mk(1, 8'hFF, 0, 8'h00, 0, 0,   0, 5'd0, 8'hFF, 8'h00);
    vecs[7]  = mk(0, 8'h00, 0, 8'h00, 0, 0,   0, 5'd0, 8'h00, 8'h00);
    vecs[8]  = mk(1, 8'h00, 1, 8'h04, 0, 0,   0, 5'd0, 8'h00, 8'h04);
    vecs[9]  = mk(1, 8'h04, 0, 8'h00, 0, 0,   0, 5'd0, 8'h00, 8'h04);
    vecs[10] = mk(1, 8'h00, 0, 8'h00, 0, 0,   0, 5'd0, 8'h00, 8'h04);
    vecs[11] = mk(1, 8'h00, 0, 8'h00, 0, 0,   0, 5'd0, 8'h04, 8'h04);
    vecs[12] = mk(1, 8'h00, 0, 8'h00, 0, 0,   1, 5'd2, 8'h04, 8'h04);
    vecs[13] = mk(1, 8'h00, 0, 8'h00, 0, 0,   1, 5'd2, 8'h04, 8'h04);
    vecs[14] = mk(1, 8'h00, 0, 8'h00, 1, 0,   0, 5'd2, 8'h00, 8'h04);
    vecs[15] = mk(1, 8'h00, 0, 8'h00, 1, 1,   0, 5'd2, 8'h00, 8'h04);
    vecs[16] = mk(1, 8'h00, 0, 8'h00, 1, 0,   0, 5'd2, 8'h00, 8'h04);

    rst_n = 1'b0; irq_src = '0; mask_we = 1'b0; mask_wdata = '0; ir_ack = 1'b0; eret = 1'b0;
    @(negedge clk);

    // Reset hold, release with all sources high, single masked-in request.
    for (int i = 0; i <= 16; i++) begin
      rst_n = vecs[i].rst_n; irq_src = vecs[i].src; mask_we = vecs[i].mwe;
      mask_wdata = vecs[i].mdat; ir_ack = vecs[i].ack; eret = vecs[i].eret;
      cyc();
      chk($sformatf("vec%0d ir_out", i), 32'(ir_out), 32'(vecs[i].exp_ir));
      chk($sformatf("vec%0d irq_id", i), 32'(irq_id), 32'(vecs[i].exp_id));
      chk($sformatf("vec%0d pending", i), 32'(pending), 32'(vecs[i].exp_pend));
      chk($sformatf("vec%0d mask", i), 32'(mask), 32'(vecs[i].exp_mask));
    end
    ir_ack = 1'b0; eret = 1'b0;

    // Two simultaneous sources: lower index first, the other after ack and eret.
    rst_n = 1'b0; cyc(); cyc(); rst_n = 1'b1;
    mask_we = 1'b1; mask_wdata = 8'hFF; cyc(); mask_we = 1'b0;
    irq_src = 8'h22; cyc(); cyc(); cyc();
    chk("prio pend", 32'(pending), 32'h22);
    chk("prio ir_pre", 32'(ir_out), 32'h0);
    cyc();
    chk("prio ir_first", 32'(ir_out), 32'h1);
    chk("prio id_first", 32'(irq_id), 32'd1);
    ir_ack = 1'b1; cyc(); ir_ack = 1'b0;
    chk("prio ack_ir", 32'(ir_out), 32'h0);
    chk("prio ack_pend", 32'(pending), 32'h20);
    cyc(); cyc();
    chk("prio serv_block", 32'(ir_out), 32'h0);
    eret = 1'b1; cyc(); eret = 1'b0;
    chk("prio eret_gap", 32'(ir_out), 32'h0);
    cyc();
    chk("prio ir_second", 32'(ir_out), 32'h1);
    chk("prio id_second", 32'(irq_id), 32'd5);
    ir_ack = 1'b1; cyc(); ir_ack = 1'b0;
    eret = 1'b1; cyc(); eret = 1'b0;
    irq_src = 8'h00;

    // Higher-priority arrival while in service waits for eret.
    irq_src = 8'h08; repeat (4) cyc(); irq_src = 8'h00;
    chk("serv id3", 32'(irq_id), 32'd3);
    ir_ack = 1'b1; cyc(); ir_ack = 1'b0;
    irq_src = 8'h01; cyc(); irq_src = 8'h00; cyc(); cyc();
    chk("serv pend0", 32'(pending), 32'h01);
    chk("serv ir_held", 32'(ir_out), 32'h0);
    cyc(); cyc();
    chk("serv ir_still", 32'(ir_out), 32'h0);
    eret = 1'b1; cyc(); eret = 1'b0;
    chk("serv eret_gap", 32'(ir_out), 32'h0);
    cyc();
    chk("serv ir_after", 32'(ir_out), 32'h1);
    chk("serv id_after", 32'(irq_id), 32'd0);
    ir_ack = 1'b1; cyc(); ir_ack = 1'b0;
    eret = 1'b1; cyc(); eret = 1'b0;

    // Mask drop while requesting withdraws the request, rewrite reissues it.
    irq_src = 8'h04; cyc(); irq_src = 8'h00; repeat (3) cyc();
    chk("mask req_ir", 32'(ir_out), 32'h1);
    chk("mask req_id", 32'(irq_id), 32'd2);
    mask_we = 1'b1; mask_wdata = 8'h00; cyc(); mask_we = 1'b0;
    chk("mask write_cycle_ir", 32'(ir_out), 32'h1);
    cyc();
    chk("mask drop_ir", 32'(ir_out), 32'h0);
    chk("mask drop_pend", 32'(pending), 32'h04);
    mask_we = 1'b1; mask_wdata = 8'h04; cyc(); mask_we = 1'b0;
    chk("mask rewrite_ir", 32'(ir_out), 32'h0);
    cyc();
    chk("mask reissue_ir", 32'(ir_out), 32'h1);
    chk("mask reissue_id", 32'(irq_id), 32'd2);

    // Reset in service with pending bits, then stray strobes.
    ir_ack = 1'b1; cyc(); ir_ack = 1'b0;
    irq_src = 8'h30; cyc(); irq_src = 8'h00; cyc(); cyc();
    chk("rst pend_pre", 32'(pending), 32'h30);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("rst pend", 32'(pending), 32'h00);
    chk("rst mask", 32'(mask), 32'h00);
    chk("rst ir", 32'(ir_out), 32'h0);
    chk("rst id", 32'(irq_id), 32'd0);
    ir_ack = 1'b1; eret = 1'b1; cyc(); ir_ack = 1'b0; eret = 1'b0;
    chk("rst strobe_ir", 32'(ir_out), 32'h0);
    chk("rst strobe_pend", 32'(pending), 32'h00);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      irq_src    = irq_src ^ (($urandom_range(0, 2) == 0) ? (N'($urandom) & N'($urandom)) : N'(0));
      mask_we    = ($urandom_range(0, 9) == 0);
      mask_wdata = N'($urandom) | N'($urandom);
      ir_ack     = ($urandom_range(0, 2) == 0);
      eret       = ($urandom_range(0, 3) == 0);
      cyc();
      chk($sformatf("rand%0d", c), {8'h0, 3'h0, ir_out, 3'h0, irq_id, pending, mask},
          {8'h0, 3'h0, 1'(m_mode == 1), 3'h0, 5'(m_id), m_pend, m_mask});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
